// File: rtl/soc_rst_sequencer.sv
// -----------------------------------------------------------------------------
// soc_rst_sequencer
//
// Reset sequencer for the SoC power-on and run-time reset domains. It sits
// beside PRCI and drives the debug, DDR and system active-low resets.
//
// Power-up order:
//   1. Wait for the PLL to be locked for hold_cycles edges.
//   2. Release debug, then hold for hold_cycles edges.
//   3. Release DDR, then wait for DDR calibration.
//   4. Release system.
//
// In RUN, a debug-module reset (dmreset) or a software reset request puts the
// system domain back into reset for hold_cycles edges. The debug and DDR
// domains are left running. Losing PLL lock in any post-lock state restarts
// the whole sequence.
//
// Optional feature (macro SOC_RST_DDR_TIMEOUT_EN):
//   - WAIT_CALIB gives up after ddr_timeout edges.
//   - On timeout, the system is released anyway and o_ddr_fail is set.
//   - o_ddr_fail stays set until i_rst or PLL loss.
//   Without the macro, WAIT_CALIB waits forever and o_ddr_fail is tied to 0.
//
// Parameters:
//   hold_cycles  cycles each timed step waits (>= 2)
//   ddr_timeout  max cycles in WAIT_CALIB, only with the macro (>= 2)
//
// Ports:
//   i_clk             system clock
//   i_rst             asynchronous active-high reset
//   i_pll_locked      PLL lock level, synchronous to i_clk
//   i_ddr_calib_done  DDR calibration complete, level
//   i_dmreset         debug-module system reset request, level
//   i_sw_rst          software reset request, 1-cycle pulse
//   o_dbg_nrst        debug/DMI domain reset, active-low
//   o_ddr_nrst        DDR controller reset, active-low
//   o_sys_nrst        cores/bus/peripherals reset, active-low
//   o_state           current FSM state (status/debug visibility)
//   o_ddr_fail        sticky DDR calibration timeout flag
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module soc_rst_sequencer #(
  parameter int hold_cycles = 16,
  parameter int ddr_timeout = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_locked,
  input  logic       i_ddr_calib_done,
  input  logic       i_dmreset,
  input  logic       i_sw_rst,
  output logic       o_dbg_nrst,
  output logic       o_ddr_nrst,
  output logic       o_sys_nrst,
  output logic [2:0] o_state,
  output logic       o_ddr_fail
);

  typedef enum logic [2:0] {
    WAIT_PLL   = 3'd0,
    DBG_REL    = 3'd1,
    WAIT_CALIB = 3'd2,
    RUN        = 3'd3,
    SYS_HOLD   = 3'd4
  } state_t;

  // Counter is wide enough for both timed waits and saturates rather than
  // wrapping, so a stuck condition can never alias back to a terminal count.
  localparam int cnt_max_c = (hold_cycles > ddr_timeout) ? hold_cycles : ddr_timeout;
  localparam int cw        = $clog2(cnt_max_c) + 1;
  localparam logic [cw-1:0] hold_last = cw'(hold_cycles - 1);
`ifdef SOC_RST_DDR_TIMEOUT_EN
  localparam logic [cw-1:0] timeout_last = cw'(ddr_timeout - 1);
`endif

  state_t        state_q, state_d;
  logic [cw-1:0] cnt_q, cnt_d, cnt_inc;
  logic [2:0]    nrst_q, nrst_d;   // {dbg, ddr, sys}
  logic          reset_req;

  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  assign reset_req = i_dmreset | i_sw_rst;

`ifdef SOC_RST_DDR_TIMEOUT_EN
  logic fail_q, fail_d;
`endif

  // Next-state / next-output logic.
  // nrst values are a pure function of the next state, so the registered
  // resets change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
`ifdef SOC_RST_DDR_TIMEOUT_EN
    fail_d  = fail_q;
`endif
    if (state_q != WAIT_PLL && !i_pll_locked) begin
      // Clock lost: everything goes back into reset immediately.
      state_d = WAIT_PLL;
      cnt_d   = '0;
`ifdef SOC_RST_DDR_TIMEOUT_EN
      fail_d  = 1'b0;
`endif
    end else begin
      case (state_q)
        WAIT_PLL: begin
          if (!i_pll_locked) begin
            cnt_d = '0;
          end else if (cnt_q == hold_last) begin
            state_d = DBG_REL;
            cnt_d   = '0;
          end
        end
        DBG_REL: begin
          if (cnt_q == hold_last) begin
            state_d = WAIT_CALIB;
            cnt_d   = '0;
          end
        end
        WAIT_CALIB: begin
          if (i_ddr_calib_done) begin
            // Calibration wins over a coincident timeout.
            state_d = RUN;
            cnt_d   = '0;
          end
`ifdef SOC_RST_DDR_TIMEOUT_EN
          else if (cnt_q == timeout_last) begin
            state_d = RUN;
            cnt_d   = '0;
            fail_d  = 1'b1;
          end
`else
          else begin
            cnt_d = cnt_q;
          end
`endif
        end
        RUN: begin
          cnt_d = '0;
          if (reset_req) begin
            state_d = SYS_HOLD;
          end
        end
        SYS_HOLD: begin
          // Hold time restarts while any request is still asserted.
          if (reset_req) begin
            cnt_d = '0;
          end else if (cnt_q == hold_last) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = WAIT_PLL;
          cnt_d   = '0;
        end
      endcase
    end

    case (state_d)
      DBG_REL:    nrst_d = 3'b100;
      WAIT_CALIB: nrst_d = 3'b110;
      SYS_HOLD:   nrst_d = 3'b110;
      RUN:        nrst_d = 3'b111;
      default:    nrst_d = 3'b000;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= WAIT_PLL;
      cnt_q   <= '0;
      nrst_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nrst_q  <= nrst_d;
    end
  end

`ifdef SOC_RST_DDR_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fail_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
    end
  end
  assign o_ddr_fail = fail_q;
`else
  assign o_ddr_fail = 1'b0;
`endif

  assign o_dbg_nrst = nrst_q[2];
  assign o_ddr_nrst = nrst_q[1];
  assign o_sys_nrst = nrst_q[0];
  assign o_state    = state_q;

endmodule
